// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with any depth >= 2, occupancy count and threshold flags,
// sticky error flags, synchronous clear, and a standard or first-word-fall-through read port.
module sync_fifo_v2 #(
  parameter int DEPTH         = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  parameter int FWFT          = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           wren,
  input  logic [DATA_WIDTH-1:0]          i_data,
  input  logic                           rden,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty,
  output logic                           almost_full,
  output logic                           almost_empty,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
  localparam logic [PW-1:0] LAST_C   = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr_reg;
  logic [PW-1:0]         wr_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  rd_acc;
  logic                  wr_acc;

  // Explicit wrap so non-power-of-two depths never touch unused slots.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign full         = (count_reg == DEPTH_C);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AFULL_C);
  assign almost_empty = (count_reg <= AEMPTY_C);
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // A read on a full FIFO frees the slot the concurrent write lands in.
  assign rd_acc = rden & ~empty;
  assign wr_acc = wren & (~full | rden);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (clr) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (rd_acc) rd_ptr_reg <= next_ptr(rd_ptr_reg);
      if (wr_acc) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      case ({wr_acc, rd_acc})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (wren & full & ~rden) overflow_reg  <= 1'b1;
      if (rden & empty)        underflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !clr) mem[wr_ptr_reg] <= i_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign o_data = mem[rd_ptr_reg];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] o_data_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                 o_data_reg <= '0;
        else if (rd_acc && !clr) o_data_reg <= mem[rd_ptr_reg];
      end
      assign o_data = o_data_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Directed bench for sync_fifo_v2: table of vectors on a DEPTH=8 standard FIFO,
// plus hand sequences for DEPTH=5 wrap, FWFT mode and asynchronous reset.
module tb_sync_fifo_v2;

  logic clk, rst;

  // DEPTH=8 standard instance
  logic       a_clr, a_wren, a_rden;
  logic [7:0] a_din, a_dout;
  logic [3:0] a_count;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf;

  // DEPTH=5 standard instance
  logic       w_clr, w_wren, w_rden;
  logic [7:0] w_din, w_dout;
  logic [2:0] w_count;
  logic       w_full, w_empty, w_af, w_ae, w_ovf, w_udf;

  // DEPTH=8 FWFT instance
  logic       f_clr, f_wren, f_rden;
  logic [7:0] f_din, f_dout;
  logic [3:0] f_count;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;

  sync_fifo_v2 #(.DEPTH(8), .DATA_WIDTH(8), .AFULL_THRESH(7), .AEMPTY_THRESH(1), .FWFT(0)) u_a (
    .clk(clk), .rst(rst), .clr(a_clr), .wren(a_wren), .i_data(a_din), .rden(a_rden),
    .o_data(a_dout), .count(a_count), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .overflow(a_ovf), .underflow(a_udf));

  sync_fifo_v2 #(.DEPTH(5), .DATA_WIDTH(8), .AFULL_THRESH(4), .AEMPTY_THRESH(1), .FWFT(0)) u_w (
    .clk(clk), .rst(rst), .clr(w_clr), .wren(w_wren), .i_data(w_din), .rden(w_rden),
    .o_data(w_dout), .count(w_count), .full(w_full), .empty(w_empty),
    .almost_full(w_af), .almost_empty(w_ae), .overflow(w_ovf), .underflow(w_udf));

  sync_fifo_v2 #(.DEPTH(8), .DATA_WIDTH(8), .AFULL_THRESH(7), .AEMPTY_THRESH(1), .FWFT(1)) u_f (
    .clk(clk), .rst(rst), .clr(f_clr), .wren(f_wren), .i_data(f_din), .rden(f_rden),
    .o_data(f_dout), .count(f_count), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_udf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       clr, wren, rden;
    logic [7:0] din;
    int         cnt;
    logic       ovf, udf;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];
  vec_t v;

  task automatic addv(input logic clr, input logic wren, input logic rden, input logic [7:0] din,
                      input int cnt, input logic ovf, input logic udf, input logic [7:0] dout);
    vec_t t;
    t.clr = clr; t.wren = wren; t.rden = rden; t.din = din;
    t.cnt = cnt; t.ovf = ovf; t.udf = udf; t.dout = dout;
    vecs.push_back(t);
  endtask

  task automatic drive_a(input logic clr, input logic wren, input logic rden, input logic [7:0] din);
    @(negedge clk);
    a_clr = clr; a_wren = wren; a_rden = rden; a_din = din;
    @(posedge clk);
    #1;
    a_clr = 1'b0; a_wren = 1'b0; a_rden = 1'b0;
  endtask

  task automatic drive_f(input logic wren, input logic rden, input logic [7:0] din);
    @(negedge clk);
    f_wren = wren; f_rden = rden; f_din = din;
    @(posedge clk);
    #1;
    f_wren = 1'b0; f_rden = 1'b0;
  endtask

  int         q[$];
  int         wrote, readn, cyc;
  logic       do_rd, do_wr;
  logic [7:0] wd, exp_d;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a_clr = 0; a_wren = 0; a_rden = 0; a_din = 0;
    w_clr = 0; w_wren = 0; w_rden = 0; w_din = 0;
    f_clr = 0; f_wren = 0; f_rden = 0; f_din = 0;

    // ---- reset values ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(a_count), 0);
    chk("rst_empty", 32'(a_empty), 1);
    chk("rst_full",  32'(a_full),  0);
    chk("rst_ae",    32'(a_ae),    1);
    chk("rst_af",    32'(a_af),    0);
    chk("rst_ovf",   32'(a_ovf),   0);
    chk("rst_udf",   32'(a_udf),   0);
    chk("rst_dout",  32'(a_dout),  0);
    chk("rst_w_empty", 32'(w_empty), 1);
    chk("rst_f_empty", 32'(f_empty), 1);
    @(negedge clk);
    rst = 1'b0;

    // ---- vector table for the DEPTH=8 standard instance ----
    for (int k = 1; k <= 8; k++) addv(0, 1, 0, 8'(k), k, 0, 0, 8'h00);
    for (int k = 1; k <= 8; k++) addv(0, 0, 1, 8'h00, 8 - k, 0, 0, 8'(k));
    addv(0, 0, 1, 8'h00, 0, 0, 1, 8'h08);   // read on empty: underflow, data held
    addv(1, 0, 0, 8'h00, 0, 0, 0, 8'h08);   // clear drops the flag
    for (int k = 0; k < 8; k++) addv(0, 1, 0, 8'(8'h11 + k), k + 1, 0, 0, 8'h08);
    addv(0, 1, 1, 8'h55, 8, 0, 0, 8'h11);   // full + simultaneous read/write
    addv(0, 1, 0, 8'hAA, 8, 1, 0, 8'h11);   // rejected write
    for (int k = 1; k <= 7; k++) addv(0, 0, 1, 8'h00, 8 - k, 1, 0, 8'(8'h11 + k));
    addv(0, 0, 1, 8'h00, 0, 1, 0, 8'h55);   // 0x55 comes out last, 0xAA never
    addv(0, 1, 1, 8'h66, 1, 1, 1, 8'h55);   // empty + simultaneous: write only
    addv(1, 1, 1, 8'h99, 0, 0, 0, 8'h55);   // clear ignores wren/rden
    addv(0, 1, 0, 8'h77, 1, 0, 0, 8'h55);
    addv(0, 0, 1, 8'h00, 0, 0, 0, 8'h77);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive_a(v.clr, v.wren, v.rden, v.din);
      $display("vec %0d clr=%0b wr=%0b rd=%0b din=%02h -> count=%0d dout=%02h ovf=%0b udf=%0b",
               i, v.clr, v.wren, v.rden, v.din, a_count, a_dout, a_ovf, a_udf);
      chk($sformatf("v%0d_count", i), 32'(a_count), 32'(v.cnt));
      chk($sformatf("v%0d_full", i),  32'(a_full),  32'(v.cnt == 8));
      chk($sformatf("v%0d_empty", i), 32'(a_empty), 32'(v.cnt == 0));
      chk($sformatf("v%0d_af", i),    32'(a_af),    32'(v.cnt >= 7));
      chk($sformatf("v%0d_ae", i),    32'(a_ae),    32'(v.cnt <= 1));
      chk($sformatf("v%0d_ovf", i),   32'(a_ovf),   32'(v.ovf));
      chk($sformatf("v%0d_udf", i),   32'(a_udf),   32'(v.udf));
      chk($sformatf("v%0d_dout", i),  32'(a_dout),  32'(v.dout));
    end

    // ---- DEPTH=5 wrap with random gaps against a scoreboard ----
    wrote = 0; readn = 0; cyc = 0;
    while (readn < 23 && cyc < 2000) begin
      do_rd = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      do_wr = (wrote < 23) && ($urandom_range(0, 2) != 0) && (q.size() < 5 || do_rd);
      wd = 8'(wrote * 7 + 3);
      @(negedge clk);
      w_wren = do_wr; w_rden = do_rd; w_din = wd;
      @(posedge clk);
      #1;
      w_wren = 1'b0; w_rden = 1'b0;
      if (do_rd) begin
        exp_d = 8'(q.pop_front());
        readn++;
        chk($sformatf("wrap_rd%0d", readn), 32'(w_dout), 32'(exp_d));
      end
      if (do_wr) begin
        q.push_back(int'(wd));
        wrote++;
      end
      $display("wrap cyc %0d wr=%0b rd=%0b count=%0d dout=%02h", cyc, do_wr, do_rd, w_count, w_dout);
      chk("wrap_count", 32'(w_count), 32'(q.size()));
      chk("wrap_full",  32'(w_full),  32'(q.size() == 5));
      cyc++;
    end
    chk("wrap_done", 32'(readn), 23);
    chk("wrap_no_err", 32'({w_ovf, w_udf}), 0);

    // ---- FWFT: word is visible before rden ----
    drive_f(1, 0, 8'h3C);
    chk("fwft_empty_after_wr", 32'(f_empty), 0);
    chk("fwft_dout_before_rd", 32'(f_dout), 32'h3C);
    drive_f(0, 1, 8'h00);
    chk("fwft_empty_after_rd", 32'(f_empty), 1);
    drive_f(1, 0, 8'hA1);
    drive_f(1, 0, 8'hB2);
    chk("fwft_head_held", 32'(f_dout), 32'hA1);
    drive_f(0, 1, 8'h00);
    chk("fwft_next_word", 32'(f_dout), 32'hB2);
    chk("fwft_count", 32'(f_count), 1);
    $display("fwft sequence done count=%0d dout=%02h", f_count, f_dout);

    // ---- asynchronous reset mid-stream ----
    drive_a(0, 0, 1, 8'h00);                   // underflow so a flag is set
    for (int k = 0; k < 5; k++) drive_a(0, 1, 0, 8'(8'hC0 + k));
    chk("pre_rst_count", 32'(a_count), 5);
    chk("pre_rst_udf",   32'(a_udf),   1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    $display("async rst asserted count=%0d empty=%0b udf=%0b", a_count, a_empty, a_udf);
    chk("arst_count", 32'(a_count), 0);
    chk("arst_empty", 32'(a_empty), 1);
    chk("arst_udf",   32'(a_udf),   0);
    chk("arst_ovf",   32'(a_ovf),   0);
    chk("arst_dout",  32'(a_dout),  0);
    @(negedge clk);
    rst = 1'b0;
    drive_a(0, 1, 0, 8'h42);
    chk("post_rst_count", 32'(a_count), 1);
    drive_a(0, 0, 1, 8'h00);
    chk("post_rst_dout", 32'(a_dout), 32'h42);
    chk("post_rst_empty", 32'(a_empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_v2.md
# sync_fifo_v2

Parametrised single-clock FIFO for streaming data between producer and consumer stages within one clock domain. It adds several features to the basic FIFO:
- simultaneous read and write in one cycle
- any depth ≥ 2, including non-power-of-two, with explicit pointer wrap
- an occupancy count with programmable almost-full and almost-empty thresholds
- selectable standard or first-word-fall-through (FWFT) read mode
- sticky overflow and underflow error flags
- a synchronous clear

## Interface
- DEPTH, 8: number of entries; ≥ 2; power of two not required.
- DATA_WIDTH, 8: width of each entry in bits.
- AFULL_THRESH, DEPTH-1: almost_full asserts when count ≥ this; range 1..DEPTH.
- AEMPTY_THRESH, 1: almost_empty asserts when count ≤ this; range 0..DEPTH-1.
- FWFT, 0: 0 = standard mode (data one cycle after read); 1 = first-word-fall-through.

Ports (CW = $clog2(DEPTH+1)):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear; empties FIFO and clears error flags.
- wren  in  1  write request.
- i_data  in  DATA_WIDTH  write data.
- rden  in  1  read request.
- o_data  out  DATA_WIDTH  read data.
- count  out  CW  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AFULL_THRESH.
- almost_empty  out  1  count ≤ AEMPTY_THRESH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

## Operation
- Storage is a DEPTH × DATA_WIDTH array, with rd_ptr and wr_ptr of width $clog2(DEPTH).
  - Each pointer increments modulo DEPTH: DEPTH-1 wraps to 0 explicitly.
  - Storage contents are not reset.
- Accepted read: rd_acc = rden & !empty.
- Accepted write: wr_acc = wren & (!full | rden).
  - When full, a simultaneous read frees the slot, so the write is accepted.
- count update per cycle:
  - +1 on wr_acc only.
  - −1 on rd_acc only.
  - unchanged when both or neither occur.
- On rd_acc, rd_ptr advances. On wr_acc, mem[wr_ptr] ← i_data and wr_ptr advances.
- Simultaneous read and write when empty: the read is rejected, the write is accepted, and underflow sets.
- Error flags:
  - overflow sets on wren & full & !rden.
  - underflow sets on rden & empty.
  - Both hold until clr or rst.
- Standard mode (FWFT=0):
  - o_data is a register loaded with mem[rd_ptr] on rd_acc.
  - o_data holds its value otherwise, including on rejected reads.
- FWFT mode (FWFT=1):
  - o_data = mem[rd_ptr] continuously.
  - The value is valid whenever empty == 0.
  - rden acknowledges and pops the presented word.
- clr:
  - Pointers, count and error flags go to zero.
  - Any wren or rden in the same cycle is ignored.
  - o_data keeps its value in standard mode.
- Status outputs (full, empty, almost_*) are functions of the registered count only. They never depend combinationally on wren or rden.

## Timing
- Reset values while rst is high:
  - count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = 0, underflow = 0.
  - o_data = 0 in standard mode; in FWFT mode o_data is undefined while empty.
  - Pointers = 0.
- rst may assert mid-operation at any time. The next rising edge after rst deasserts is a normal operating edge.
- Write-to-empty latency: after a write to an empty FIFO, empty deasserts on the following edge.
  - FWFT: the word appears on o_data in that same cycle.
  - Standard: the word appears one cycle after the rden that pops it.
- Read latency:
  - Standard: 1 cycle from rd_acc to o_data.
  - FWFT: 0 cycles, since data is present before rden.
- Throughput: one write and one read per cycle, sustained indefinitely at any occupancy from 1 to DEPTH-1. This also holds at DEPTH when the read and write are simultaneous.
- Flags update on the same edge as count.

## Test plan
- Reset and fill, DEPTH=8, FWFT=0, AFULL_THRESH=7, AEMPTY_THRESH=1:
  - Write 0x01..0x08 on consecutive cycles, then drain with rden for 8 cycles.
  - Required: count steps 1..8; almost_full at count 7; full at count 8.
  - Required: o_data = 0x01..0x08, each one cycle after its read.
  - Required: empty = 1 after the drain; no error flag set.
- Overflow and underflow:
  - On a full FIFO, assert wren with i_data = 0xAA and rden = 0. Required: overflow = 1, count stays 8, 0xAA is never read.
  - On an empty FIFO, assert rden. Required: underflow = 1 and o_data unchanged.
  - Assert clr. Required: both flags clear.
- Simultaneous read and write:
  - At count 8, assert wren (0x55) and rden together. Required: count stays 8, no overflow, and 0x55 is read last.
  - At count 0, assert the same. Required: count becomes 1 and underflow = 1.
- Wrap with DEPTH=5:
  - Run 23 interleaved write/read pairs with random gaps.
  - Required: the output order matches a scoreboard, and pointers wrap at 4→0.
- FWFT=1:
  - Write 0x3C into an empty FIFO. Required: next cycle empty = 0 and o_data = 0x3C before any rden.
  - Assert rden. Required: empty = 1 on the next edge.
- Asynchronous reset mid-stream:
  - Assert rst between clock edges with count = 5.
  - Required: count = 0, empty = 1 and flags clear immediately, without waiting for a clk edge.
